// File: rtl/word_bit_serializer.sv
// Parallel-to-serial word feeder: accepts WIDTH-bit words on valid/ready and
// emits them MSB-first, one bit per clock, with first/last frame markers.
module word_bit_serializer #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic             out_bit,
  output logic             out_valid,
  output logic             out_first,
  output logic             out_last,
  output logic             busy,
  output logic [CNT_W-1:0] word_cnt
);

  localparam int IDX_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WIDTH - 1);

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  state_t           state;
  state_t           state_next;
  logic [WIDTH-1:0] shreg;
  logic [IDX_W-1:0] idx;
  logic             at_last;
  logic             accept;

  assign at_last = (idx == LAST_IDX);
  assign accept  = in_valid && in_ready;

  // State register.
  // NOTE: sequential state uses non-blocking (<=) so every flop samples
  // pre-edge values; blocking here would create order-dependent races.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // Next-state logic. The LSB cycle may reload directly, giving zero-bubble
  // back-to-back words.
  // NOTE: default assignment first so no path leaves state_next unassigned,
  // which would otherwise infer a latch.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (accept) state_next = SHIFT;
      SHIFT:   if (at_last && !accept) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Output decode: everything but in_ready comes from registered state only.
  always_comb begin
    busy      = (state == SHIFT);
    out_valid = (state == SHIFT);
    out_bit   = (state == SHIFT) && shreg[WIDTH-1];
    out_first = (state == SHIFT) && (idx == '0);
    out_last  = (state == SHIFT) && at_last;
    in_ready  = !rst && ((state == IDLE) || ((state == SHIFT) && at_last));
  end

  // Shift datapath and completed-word counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      shreg    <= '0;
      idx      <= '0;
      word_cnt <= '0;
    end else begin
      if (accept) begin
        shreg <= in_data;
        idx   <= '0;
      end else if (state == SHIFT) begin
        shreg <= shreg << 1;
        idx   <= at_last ? '0 : idx + IDX_W'(1);
      end
      if ((state == SHIFT) && at_last)
        word_cnt <= word_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_word_bit_serializer.sv
// Scoreboard bench for word_bit_serializer: three lanes (WIDTH=8/CNT_W=16,
// WIDTH=8/CNT_W=2, WIDTH=1/CNT_W=2), directed scenarios then random traffic.
module tb_word_bit_serializer;

  typedef struct packed {
    logic b;
    logic f;
    logic l;
  } exp_bit_t;

  logic clk;
  int   n_cmp = 0;
  int   n_bad = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input int lane_id, input string name,
                       input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL lane%0d %s: got %0h, expected %0h at %0t",
               lane_id, name, act, exp, $time);
    end
  endtask

  for (genvar g = 0; g < 3; g++) begin : lane
    localparam int W = (g == 2) ? 1 : 8;
    localparam int C = (g == 0) ? 16 : 2;

    logic         rst;
    logic [W-1:0] in_data;
    logic         in_valid;
    logic         in_ready;
    logic         out_bit;
    logic         out_valid;
    logic         out_first;
    logic         out_last;
    logic         busy;
    logic [C-1:0] word_cnt;

    exp_bit_t     q[$];
    logic [C-1:0] model_cnt = '0;
    bit           started   = 1'b0;
    bit           done_l    = 1'b0;

    word_bit_serializer #(.WIDTH(W), .CNT_W(C)) dut (
      .clk      (clk),
      .rst      (rst),
      .in_data  (in_data),
      .in_valid (in_valid),
      .in_ready (in_ready),
      .out_bit  (out_bit),
      .out_valid(out_valid),
      .out_first(out_first),
      .out_last (out_last),
      .busy     (busy),
      .word_cnt (word_cnt)
    );

    // One clock of stimulus; an accepted word is expanded into its bit stream.
    task automatic cycle(input logic v, input logic [63:0] d, input logic r,
                         output logic hs);
      in_valid = v;
      in_data  = W'(d);
      rst      = r;
      @(negedge clk);
      #1;
      hs = v && in_ready && !r;
      @(posedge clk);
      if (hs)
        for (int k = 0; k < W; k++)
          q.push_back('{b: in_data[W-1-k], f: (k == 0), l: (k == W - 1)});
      #1;
    endtask

    task automatic send(input logic [63:0] d);
      logic hs;
      int   n;
      hs = 1'b0;
      n  = 0;
      while (!hs && n < 2 * W + 4) begin
        cycle(1'b1, d, 1'b0, hs);
        n++;
      end
      check(g, "accept", 64'(hs), 64'd1);
    endtask

    task automatic idle(input int n);
      logic hs;
      repeat (n) cycle(1'b0, 64'd0, 1'b0, hs);
    endtask

    // Driver: directed scenarios, then random words with occasional resets.
    initial begin
      logic        hs;
      logic        pv;
      logic        r;
      logic [63:0] pd;
      in_valid = 1'b0;
      in_data  = '0;
      rst      = 1'b1;
      cycle(1'b0, 64'd0, 1'b1, hs);
      started = 1'b1;
      cycle(1'b0, 64'd0, 1'b1, hs);
      send(64'hA5); idle(W + 2);                       // single word
      send(64'hA5); send(64'h0F); idle(W + 2);         // back-to-back
      send(64'hA5); idle(W + 3); send(64'h0F); idle(W + 2);  // gap
      send(64'hFF); idle(3); cycle(1'b0, 64'd0, 1'b1, hs);   // reset mid-word
      send(64'h80); idle(W + 2);
      for (int i = 0; i < 5; i++) send({$urandom, $urandom});  // counter wrap
      idle(W + 2);
      send(64'd1); send(64'd0); send(64'd1); idle(W + 2);
      pv = 1'b0;
      pd = '0;
      repeat (300) begin
        if (!pv && $urandom_range(0, 99) < 60) begin
          pv = 1'b1;
          pd = {$urandom, $urandom};
        end
        r = ($urandom_range(0, 99) < 2);
        cycle(pv, pd, r, hs);
        if (hs || r) pv = 1'b0;
      end
      idle(W + 2);
      done_l = 1'b1;
    end

    // Monitor: pop the expected bit for this cycle and compare every output.
    always @(negedge clk) begin
      exp_bit_t e;
      logic     ev;
      logic     er;
      if (started) begin
        er = !rst && (q.size() <= 1);
        if (q.size() > 0) begin
          e  = q.pop_front();
          ev = 1'b1;
        end else begin
          e  = '0;
          ev = 1'b0;
        end
        check(g, "out_valid", 64'(out_valid), 64'(ev));
        check(g, "busy",      64'(busy),      64'(ev));
        check(g, "out_bit",   64'(out_bit),   64'(e.b));
        check(g, "out_first", 64'(out_first), 64'(e.f));
        check(g, "out_last",  64'(out_last),  64'(e.l));
        check(g, "in_ready",  64'(in_ready),  64'(er));
        check(g, "word_cnt",  64'(word_cnt),  64'(model_cnt));
        if (rst) begin
          q.delete();
          model_cnt = '0;
        end else if (ev && e.l) begin
          model_cnt = model_cnt + 1'b1;
        end
      end
    end
  end

  initial begin
    wait (lane[0].done_l && lane[1].done_l && lane[2].done_l);
    @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200us;
    $display("FAIL timeout: bench did not complete, got running, expected done");
    $fatal(1);
  end

endmodule

// File: doc/word_bit_serializer.md
Name: word_bit_serializer

Overview:
- Upstream feeder for the serial divisible-by-N checker.
- Accepts parallel words over a valid/ready handshake and emits each word MSB-first, one bit per clock.
- Provides out_first and out_last frame markers so downstream logic can clear its remainder at word boundaries.
- Supports zero-bubble back-to-back words and keeps a running count of completed words.

Parameters:
WIDTH, 8, word width in bits; legal range 1..64.
CNT_W, 16, width of the completed-word counter.

Ports:
clk  input  1  clock, all state updates on rising edge
rst  input  1  reset, synchronous, active-high
in_data  input  WIDTH  parallel word, sampled on handshake
in_valid  input  1  upstream word available
in_ready  output  1  block can accept a word this cycle
out_bit  output  1  current serial bit, MSB first
out_valid  output  1  out_bit is meaningful this cycle
out_first  output  1  out_bit is the MSB of a word
out_last  output  1  out_bit is the LSB of a word
busy  output  1  a word is currently being shifted out
word_cnt  output  CNT_W  number of words fully emitted, wraps modulo 2^CNT_W

Behaviour:
- States: IDLE and SHIFT. The bit index idx is a counter 0..WIDTH-1 (width max(1, clog2(WIDTH))).
- Handshake fires when in_valid && in_ready are both high at a rising edge.
- in_ready = !rst && (state==IDLE || (state==SHIFT && idx==WIDTH-1)). It is combinational, so a new word can load in the same cycle the LSB is presented.
- On handshake:
  - shift register <= in_data
  - idx <= 0
  - state <= SHIFT
- Latency: a word accepted in cycle t presents bits in cycles t+1 .. t+WIDTH.
  - Cycle t+1+k: out_bit = in_data[WIDTH-1-k].
  - out_first is high only at k=0; out_last is high only at k=WIDTH-1.
- In SHIFT with idx<WIDTH-1: shift left by one, idx++. in_valid is ignored (in_ready=0).
- In SHIFT with idx==WIDTH-1 (last bit):
  - word_cnt increments at the end of this cycle.
  - If a handshake occurs, load the new word and stay in SHIFT. The next cycle has out_first=1 with no idle bubble.
  - Otherwise go to IDLE.
- In IDLE:
  - out_valid, out_first, out_last and busy are 0.
  - out_bit is held at 0.
- busy = (state==SHIFT).
- All outputs except in_ready are registered or decoded from registered state; no combinational path from in_data to out_bit.
- WIDTH=1:
  - Every emitted bit has both out_first=1 and out_last=1.
  - in_ready stays 1 continuously, so a new word can be accepted every cycle.
- Reset, including mid-word:
  - Next state is IDLE; shift register, idx, out_bit and word_cnt are cleared to 0.
  - out_valid, out_first, out_last and busy are 0.
  - in_ready is 0 during the reset cycle.
  - A partially emitted word is discarded and not counted.
- word_cnt wraps from 2^CNT_W-1 to 0 with no flag.
- Downstream has no backpressure: the consumer takes one bit per cycle whenever out_valid=1.

Test Plan:
- Single word, WIDTH=8: in_data=0xA5 accepted at cycle 0.
  - Cycles 1-8: out_bit = 1,0,1,0,0,1,0,1.
  - out_first only at cycle 1, out_last only at cycle 8.
  - word_cnt=1 from cycle 9; IDLE at cycle 9.
- Back-to-back: 0xA5 then 0x0F, with in_valid held high.
  - Second handshake happens at cycle 8.
  - Cycles 9-16: out_bit = 0,0,0,0,1,1,1,1, with out_valid continuous from cycle 1 to 16.
  - word_cnt=2 at cycle 17.
- Gap between words: in_valid low for 3 cycles after the first word.
  - out_valid=0 and busy=0 during the gap.
  - The second word starts with out_first=1 one cycle after its handshake.
- Reset mid-word: rst pulsed at cycle 4 of 0xFF.
  - Cycle 5: all outputs 0, word_cnt=0, in_ready=1.
  - The next word 0x80 serializes correctly as 1,0,0,0,0,0,0,0.
- Counter wrap with CNT_W=2: five consecutive words produce the sequence 1,2,3,0,1.
- WIDTH=1: in_valid held high with data 1,0,1.
  - out_bit = 1,0,1 on consecutive cycles, each with out_first=out_last=1.
  - in_ready stays 1 throughout.
